npu_result_reader: RTL and testbench

Host-side readback path for NPU inference results. It captures the 8-bit result stream leaving `npu_top`, packs the bytes little-endian into 32-bit words in a small result buffer, and exposes a status word plus the buffer to the host over a register-read port. It sits alongside `memory_write`, which is the host→NPU direction: the host arms capture through `control_reg`, runs the NPU, polls status, then reads the results back.

---
 rtl/npu_rd_pkg.sv | 41 ++++
 rtl/npu_result_reader_result_ram.sv | 35 +++
 rtl/npu_result_reader.sv | 180 ++++++++++++++++++
 tb/tb_npu_result_reader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_rd_pkg.sv
// Shared types and constants for the NPU result readback path.
package npu_rd_pkg;

    // Capture sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } rd_state_t;

    // Status word bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    // Host control word fields
    localparam int CTRL_ARM_BIT = 0;
    localparam int CTRL_CNT_LSB = 8;
    localparam int CTRL_CNT_MSB = 15;

    // Host address of the status word
    localparam int ADDR_STATUS = 0;

    // Assemble the host-visible status word; all unlisted bits stay 0.
    function automatic logic [31:0] build_status(
        input logic       busy,
        input logic       done_f,
        input logic       ovf,
        input logic [7:0] cnt
    );
        logic [31:0] r;
        r                  = 32'd0;
        r[ST_BUSY]         = busy;
        r[ST_DONE]         = done_f;
        r[ST_OVF]          = ovf;
        r[ST_CNT_LSB +: 8] = cnt;
        return r;
    endfunction

endpackage

// File: rtl/npu_result_reader_result_ram.sv
// Result buffer: DEPTH x 32 simple dual-port RAM, one write port and one
// registered read port. A same-address read/write returns the old word.
module result_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [31:0]   i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [31:0]   o_rd_data
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_data;

    // Write port: store a packed result word
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: registered, holds its value when not enabled
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/npu_result_reader.sv
// Captures the NPU result byte stream, packs it little-endian into 32-bit
// words in the result buffer and serves status/buffer reads to the host.
module npu_result_reader
    import npu_rd_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       control_reg,
    input  logic [7:0]        d_out,
    input  logic              d_out_valid,
    input  logic              chipselect,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    output logic [31:0]       readdata,
    output logic              done,
    output logic              overflow
);

    localparam int               RAM_AW    = $clog2(DEPTH);
    localparam logic [8:0]       CAP_BYTES = 9'(4 * DEPTH);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ADDR_STATUS);
    localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(DEPTH);

    // Capture state
    rd_state_t   r_state;
    logic        r_arm_q;
    logic [7:0]  r_cnt;
    logic [7:0]  r_byte_count;
    logic [31:0] r_pack;
    logic        r_done;
    logic        r_overflow;

    // Read path state
    logic        r_rd_from_ram;
    logic [31:0] r_rd_word;

    // Capture datapath
    logic              w_arm_edge;
    logic [7:0]        w_ctrl_cnt;
    logic [1:0]        w_lane;
    logic [7:0]        w_cnt_next;
    logic              w_last;
    logic              w_in_range;
    logic              w_take;
    logic              w_flush;
    logic [31:0]       w_pack_merged;
    logic              w_wr_en;
    logic [RAM_AW-1:0] w_wr_addr;

    // Read datapath
    logic              w_rd_hit;
    logic              w_rd_is_status;
    logic              w_rd_in_ram;
    logic [RAM_AW-1:0] w_ram_rd_addr;
    logic [31:0]       w_ram_q;
    logic              w_unused_ctrl;

    assign w_arm_edge = control_reg[CTRL_ARM_BIT] & ~r_arm_q;
    assign w_ctrl_cnt = control_reg[CTRL_CNT_MSB:CTRL_CNT_LSB];
    assign w_lane     = r_cnt[1:0];
    assign w_cnt_next = r_cnt + 8'd1;
    assign w_last     = (w_cnt_next == r_byte_count);
    assign w_in_range = ({1'b0, r_cnt} < CAP_BYTES);
    // An arm edge takes priority over a coinciding byte, which is dropped.
    assign w_take     = (r_state == CAPTURE) & d_out_valid & ~w_arm_edge;
    assign w_flush    = (w_lane == 2'd3) | w_last;
    assign w_wr_en    = w_take & w_in_range & w_flush;
    assign w_wr_addr  = r_cnt[RAM_AW+1:2];

    assign w_unused_ctrl = ^{control_reg[31:CTRL_CNT_MSB+1], control_reg[CTRL_CNT_LSB-1:CTRL_ARM_BIT+1]};

    // Merge the incoming byte into its lane of the pack register
    always_comb begin
        w_pack_merged = r_pack;
        case (w_lane)
            2'd0:    w_pack_merged[7:0]   = d_out;
            2'd1:    w_pack_merged[15:8]  = d_out;
            2'd2:    w_pack_merged[23:16] = d_out;
            default: w_pack_merged[31:24] = d_out;
        endcase
    end

    // Capture sequencer: arm edge detect, byte counting, packing, done/overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_arm_q      <= 1'b0;
            r_cnt        <= 8'd0;
            r_byte_count <= 8'd0;
            r_pack       <= 32'd0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_arm_q <= control_reg[CTRL_ARM_BIT];
            if (w_arm_edge) begin
                r_cnt        <= 8'd0;
                r_pack       <= 32'd0;
                r_overflow   <= 1'b0;
                r_byte_count <= w_ctrl_cnt;
                if (w_ctrl_cnt == 8'd0) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= CAPTURE;
                    r_done  <= 1'b0;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    CAPTURE: begin
                        if (d_out_valid) begin
                            r_cnt <= w_cnt_next;
                            if (!w_in_range) begin
                                r_overflow <= 1'b1;
                            end
                            if (w_flush) begin
                                r_pack <= 32'd0;
                            end else begin
                                r_pack <= w_pack_merged;
                            end
                            if (w_last) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= DONE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign w_rd_hit       = chipselect & read;
    assign w_rd_is_status = (address == A_STATUS);
    assign w_rd_in_ram    = !w_rd_is_status && (address <= A_LAST);
    assign w_ram_rd_addr  = address[RAM_AW-1:0] - {{(RAM_AW-1){1'b0}}, 1'b1};

    result_ram #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_result_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_pack_merged),
        .i_rd_en   (w_rd_hit & w_rd_in_ram),
        .i_rd_addr (w_ram_rd_addr),
        .o_rd_data (w_ram_q)
    );

    // Status/zero read path, registered in step with the RAM read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_from_ram <= 1'b0;
            r_rd_word     <= 32'd0;
        end else if (w_rd_hit) begin
            r_rd_from_ram <= w_rd_in_ram;
            if (w_rd_is_status) begin
                r_rd_word <= build_status((r_state == CAPTURE), r_done, r_overflow, r_cnt);
            end else begin
                r_rd_word <= 32'd0;
            end
        end
    end

    assign readdata = r_rd_from_ram ? w_ram_q : r_rd_word;
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_npu_result_reader.sv
// Self-checking bench for npu_result_reader with a byte-level buffer model.
module tb_npu_result_reader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       control_reg;
    logic [7:0]        d_out;
    logic              d_out_valid;
    logic              chipselect;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [31:0]       readdata;
    logic              done;
    logic              overflow;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model of the result buffer: word contents and whether known
    logic [31:0] exp_mem [DEPTH];
    bit          known   [DEPTH];

    always #5 clk = ~clk;

    npu_result_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .control_reg (control_reg),
        .d_out       (d_out),
        .d_out_valid (d_out_valid),
        .chipselect  (chipselect),
        .read        (read),
        .address     (address),
        .readdata    (readdata),
        .done        (done),
        .overflow    (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Produce a rising edge on the arm bit with the given byte count.
    task automatic arm(input logic [7:0] n, input bit with_byte);
        control_reg = {16'd0, n, 8'd0};
        tick();
        control_reg[0] = 1'b1;
        if (with_byte) begin
            d_out       = 8'hEE;
            d_out_valid = 1'b1;
        end
        tick();
        d_out_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        d_out       = b;
        d_out_valid = 1'b1;
        tick();
        d_out_valid = 1'b0;
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, output logic [31:0] data);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        tick();
        data       = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    function automatic logic [31:0] status_word(bit busy, bit dn, bit ovf, int cnt);
        return {16'd0, 8'(cnt), 5'd0, ovf, dn, busy};
    endfunction

    // Update the buffer model after a capture: n_sent bytes were accepted out
    // of n_total requested. Complete words land in the buffer; the word holding
    // the final byte lands too (zero-padded) only if the capture finished.
    task automatic model_commit(input logic [7:0] bytes[$], input int n_total);
        int n_sent;
        n_sent = bytes.size();
        for (int w = 0; w < DEPTH; w++) begin
            int lo;
            bit complete;
            bit holds_last;
            logic [31:0] val;
            lo = 4 * w;
            if (lo < n_sent) begin
                complete   = (lo + 3 < n_sent);
                holds_last = (n_sent == n_total) && (n_total - 1 <= lo + 3);
                if (complete || holds_last) begin
                    val = 32'd0;
                    for (int k = 0; k < 4; k++) begin
                        if (lo + k < n_sent) val[8*k +: 8] = bytes[lo + k];
                    end
                    exp_mem[w] = val;
                    known[w]   = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset       = 1'b1;
        control_reg = 32'd0;
        d_out       = 8'd0;
        d_out_valid = 1'b0;
        chipselect  = 1'b0;
        read        = 1'b0;
        address     = '0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        tick(); tick(); tick();
        vectors++;
        if (readdata !== 32'd0) begin miscompares++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'd0); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b0;
        tick();
        host_read(5'd0, rd);
        vectors++;
        if (rd !== 32'h0000_0000) begin miscompares++; $display("FAIL reset_status: got %h expected %h", rd, 32'h0); end
    endtask

    task automatic test_four();
        logic [7:0]  q[$];
        logic [31:0] rd;
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        arm(8'd4, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(q[i]);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL four_done_early: got %b expected 0", done); end
        send_byte(q[3]);
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL four_done: got %b expected 1", done); end
        model_commit(q, 4);
        host_read(5'd1, rd);
        vectors++;
        if (rd !== 32'h4433_2211) begin miscompares++; $display("FAIL four_word1: got %h expected %h", rd, 32'h44332211); end
        send_byte(8'h99);
        host_read(5'd0, rd);
        vectors++;
        if (rd !== 32'h0000_0402) begin miscompares++; $display("FAIL four_status: got %h expected %h", rd, 32'h402); end
        // Reads with read or chipselect low must hold readdata
        chipselect = 1'b1; read = 1'b0; address = 5'd1;
        tick();
        chipselect = 1'b0; read = 1'b1;
        tick();
        read = 1'b0;
        vectors++;
        if (readdata !== 32'h0000_0402) begin miscompares++; $display("FAIL read_hold: got %h expected %h", readdata, 32'h402); end
    endtask

    task automatic test_zero_count();
        logic [31:0] rd;
        arm(8'd0, 1'b0);
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b expected 1", done); end
        host_read(5'd0, rd);
        vectors++;
        if (rd !== 32'h0000_0002) begin miscompares++; $display("FAIL zero_status: got %h expected %h", rd, 32'h2); end
    endtask

    task automatic test_gaps();
        logic [7:0]  q[$];
        logic [31:0] rd;
        logic [31:0] want [3];
        want = '{32'h0403_0201, 32'h0807_0605, 32'h0000_0A09};
        q = {};
        arm(8'd10, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            send_byte(8'(i));
            q.push_back(8'(i));
            if (i == 5) begin
                host_read(5'd0, rd);
                vectors++;
                if (rd !== 32'h0000_0501) begin miscompares++; $display("FAIL gaps_busy_status: got %h expected %h", rd, 32'h501); end
            end
        end
        model_commit(q, 10);
        for (int w = 0; w < 3; w++) begin
            host_read(5'(w + 1), rd);
            vectors++;
            if (rd !== want[w]) begin miscompares++; $display("FAIL gaps_word%0d: got %h expected %h", w + 1, rd, want[w]); end
        end
        host_read(5'd0, rd);
        vectors++;
        if (rd !== 32'h0000_0A02) begin miscompares++; $display("FAIL gaps_status: got %h expected %h", rd, 32'hA02); end
    endtask

    task automatic test_rearm();
        logic [7:0]  first[$];
        logic [7:0]  q[$];
        logic [31:0] rd;
        first = {};
        arm(8'd4, 1'b0);
        for (int i = 0; i < 2; i++) begin
            first.push_back(8'($urandom_range(0, 255)));
            send_byte(first[i]);
        end
        model_commit(first, 4);
        // Re-arm with a byte arriving on the arm edge; that byte is dropped
        arm(8'd4, 1'b1);
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) send_byte(q[i]);
        model_commit(q, 4);
        host_read(5'd1, rd);
        vectors++;
        if (rd !== 32'hDDCC_BBAA) begin miscompares++; $display("FAIL rearm_word1: got %h expected %h", rd, 32'hDDCCBBAA); end
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL rearm_done: got %b expected 1", done); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL rearm_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [7:0]  q[$];
        logic [31:0] rd;
        q = {};
        arm(8'd68, 1'b0);
        for (int i = 0; i < 68; i++) begin
            q.push_back(8'($urandom_range(0, 255)));
            send_byte(q[i]);
            if (i == 63) begin
                vectors++;
                if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
            if (i == 64) begin
                vectors++;
                if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b expected 1", overflow); end
            end
        end
        model_commit(q, 68);
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL ovf_done: got %b expected 1", done); end
        host_read(5'd0, rd);
        vectors++;
        if (rd !== 32'h0000_4406) begin miscompares++; $display("FAIL ovf_status: got %h expected %h", rd, 32'h4406); end
        host_read(5'd16, rd);
        vectors++;
        if (rd !== {q[63], q[62], q[61], q[60]}) begin miscompares++; $display("FAIL ovf_word16: got %h expected %h", rd, {q[63], q[62], q[61], q[60]}); end
        for (int w = 0; w < DEPTH; w++) begin
            host_read(5'(w + 1), rd);
            vectors++;
            if (rd !== exp_mem[w]) begin miscompares++; $display("FAIL ovf_buf_word%0d: got %h expected %h", w + 1, rd, exp_mem[w]); end
        end
        host_read(5'd17, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL ovf_addr17: got %h expected 0", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        arm(8'd8, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
        reset = 1'b1;
        #1;
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %b expected 0", done); end
        vectors++;
        if (readdata !== 32'd0) begin miscompares++; $display("FAIL rstmid_readdata: got %h expected 0", readdata); end
        control_reg = 32'd0;
        tick();
        reset = 1'b0;
        tick();
        host_read(5'd0, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL rstmid_status: got %h expected 0", rd); end
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
        host_read(5'd0, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("FAIL rstmid_idle_ignore: got %h expected 0", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        for (int it = 0; it < 8; it++) begin
            logic [7:0] q[$];
            int n;
            int n_send;
            bit abort;
            n      = $urandom_range(1, 70);
            abort  = ($urandom_range(0, 3) == 0) && (n >= 2);
            n_send = abort ? n / 2 : n;
            q = {};
            arm(8'(n), 1'b0);
            for (int i = 0; i < n_send; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
                q.push_back(8'($urandom_range(0, 255)));
                send_byte(q[i]);
            end
            model_commit(q, n);
            if (!abort) begin
                host_read(5'd0, rd);
                vectors++;
                if (rd !== status_word(1'b0, 1'b1, n > 4 * DEPTH, n)) begin
                    miscompares++;
                    $display("FAIL rand%0d_status: got %h expected %h", it, rd, status_word(1'b0, 1'b1, n > 4 * DEPTH, n));
                end
                for (int w = 0; w < DEPTH; w++) begin
                    if (known[w]) begin
                        host_read(5'(w + 1), rd);
                        vectors++;
                        if (rd !== exp_mem[w]) begin miscompares++; $display("FAIL rand%0d_word%0d: got %h expected %h", it, w + 1, rd, exp_mem[w]); end
                    end
                end
                host_read(5'(DEPTH + 1 + $urandom_range(0, 14)), rd);
                vectors++;
                if (rd !== 32'd0) begin miscompares++; $display("FAIL rand%0d_oob: got %h expected 0", it, rd); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_four();
        test_zero_count();
        test_gaps();
        test_rearm();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
